ser_nibble_rx: RTL and testbench

- Receive side of the serial nibble link; the mating transmitter is driven from bus writes in the BA12 window.
- Deserialises asynchronous frames on `sdin` and checks parity. Good nibbles go into a 2-deep FIFO.
- The host reads data or status through the same decoded bus window: ~sser_n & ~ba13 & ba12 & br_w.

---
 rtl/ser_nibble_rx_if.sv | 26 ++
 rtl/ser_nibble_rx.sv | 205 ++++++++++++++++++++
 tb/tb_ser_nibble_rx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ser_nibble_rx_if.sv
// Host-side bus of the serial nibble receiver: decoded read window plus
// the data/status return path and the status flags.
interface ser_nibble_rx_if;
    logic       sser_n;   // serial-port select, active low
    logic       ba13;     // must be 0 for select
    logic       ba12;     // must be 1 for select
    logic       ba7;      // 0 = data register, 1 = status register
    logic       br_w;     // read strobe, one pulse per access
    logic [3:0] bd;       // read data, 4'h0 when not driving
    logic       bd_oe;    // bus drive enable
    logic       rdy;      // FIFO non-empty
    logic       perr;     // sticky parity/framing error
    logic       ovr;      // sticky overrun

    // Host side: issues reads, observes data and flags.
    modport master (
        output sser_n, ba13, ba12, ba7, br_w,
        input  bd, bd_oe, rdy, perr, ovr
    );

    // Receiver side.
    modport slave (
        input  sser_n, ba13, ba12, ba7, br_w,
        output bd, bd_oe, rdy, perr, ovr
    );
endinterface

// File: rtl/ser_nibble_rx.sv
// Serial nibble receiver: oversampled async frame deserialiser
// (start, d0..d3 LSB first, odd parity, stop) feeding a small FIFO that the
// host drains through a decoded read window. Bad frames set a sticky parity
// error, pushes into a full FIFO set a sticky overrun; a status read clears
// both on its trailing edge.
module ser_nibble_rx #(
    parameter int OVS   = 4,   // clocks per bit cell, >= 3
    parameter int DEPTH = 2    // FIFO depth, power of two 2..8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sdin,
    ser_nibble_rx_if.slave  bus
);

    localparam int CW   = $clog2(OVS);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0]   CNT_HALF = CW'(OVS / 2);
    localparam logic [CW-1:0]   CNT_LAST = CW'(OVS - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t          state, state_nx;
    logic            sync1, sd, sd_prev;
    logic [CW-1:0]   cnt;
    logic [1:0]      bcnt;
    logic [3:0]      sr;
    logic            par_q;
    logic            cnt_rst, shift_en, par_en, stop_smp;
    logic            good, bad;

    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CNTW-1:0] count;
    logic            empty, full, push, pop, ovr_set;
    logic [3:0]      head;

    logic            sel, dsel_q, ssel_q, clr;
    logic            perr_q, ovr_q;

    // Two-flop synchroniser plus one history flop for edge detection.
    // Reset to the idle-high line level so release never looks like a start edge.
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sd      <= 1'b1;
            sd_prev <= 1'b1;
        end else begin
            sync1   <= sdin;
            sd      <= sync1;
            sd_prev <= sd;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state and sample strobes. A falling edge cannot be seen in IDLE
    // until the line has returned high, which re-arms after a low stop bit.
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        state_nx = state;
        cnt_rst  = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_smp = 1'b0;
        case (state)
            S_IDLE: begin
                if (sd_prev && !sd) begin
                    cnt_rst  = 1'b1;
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_rst  = 1'b1;
                    state_nx = sd ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_rst  = 1'b1;
                    shift_en = 1'b1;
                    if (bcnt == 2'd3) state_nx = S_PAR;
                end
            end
            S_PAR: begin
                if (cnt == CNT_LAST) begin
                    cnt_rst  = 1'b1;
                    par_en   = 1'b1;
                    state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_rst  = 1'b1;
                    stop_smp = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Cell counter, data-bit counter, shift register and parity capture.
    // bcnt wraps back to 0 after exactly four data samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            bcnt  <= '0;
            sr    <= '0;
            par_q <= 1'b0;
        end else begin
            cnt <= cnt_rst ? '0 : cnt + CW'(1);
            if (shift_en) begin
                sr   <= {sd, sr[3:1]};
                bcnt <= bcnt + 2'd1;
            end
            if (par_en) par_q <= sd;
        end
    end

    // Frame verdict at the stop sample: valid stop and odd parity overall.
    assign good = stop_smp && sd && (^{sr, par_q});
    assign bad  = stop_smp && !good;

    // Bus decode; access type is remembered so the trailing edge of br_w
    // can pop (data) or clear flags (status).
    assign sel = !bus.sser_n && !bus.ba13 && bus.ba12 && bus.br_w;

    // Registered access type for trailing-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsel_q <= 1'b0;
            ssel_q <= 1'b0;
        end else begin
            dsel_q <= sel && !bus.ba7;
            ssel_q <= sel && bus.ba7;
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign pop     = dsel_q && !bus.br_w && !empty;
    assign clr     = ssel_q && !bus.br_w;
    // A pop on the same clock frees a slot, so a full FIFO still accepts the push.
    assign push    = good && (!full || pop);
    assign ovr_set = good && full && !pop;

    // FIFO storage write.
    // NOTE: storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= sr;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flags; a new error on the clearing clock wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            perr_q <= (perr_q && !clr) || bad;
            ovr_q  <= (ovr_q && !clr) || ovr_set;
        end
    end

    assign head      = empty ? 4'h0 : mem[rptr];
    assign bus.rdy   = !empty;
    assign bus.perr  = perr_q;
    assign bus.ovr   = ovr_q;
    assign bus.bd_oe = sel;
    assign bus.bd    = !sel    ? 4'h0 :
                       bus.ba7 ? {ovr_q, perr_q, full, !empty} : head;

endmodule

// File: tb/tb_ser_nibble_rx.sv
// Bench for ser_nibble_rx: directed frames on sdin, bus reads through the
// interface. Each read pushes its expected bd onto a queue; a monitor pops
// and compares on the first cycle of every bus drive.
module tb_ser_nibble_rx;
    localparam int OVS   = 4;
    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sdin  = 1'b1;

    ser_nibble_rx_if bus ();

    ser_nibble_rx #(.OVS(OVS), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sdin  (sdin),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] exp_q  [$];
    string      name_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    logic       mon_prev;
    logic [3:0] mon_exp;
    string      mon_name;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives the first nbits cells of a frame; bit 0 is the start bit.
    // Must be entered on a falling clock edge; returns on one.
    task automatic send_frame(input logic [3:0] nib, input logic par, input int nbits);
        logic [6:0] bits;
        bits = {1'b1, par, nib, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            sdin = bits[i];
            repeat (OVS) @(negedge clk);
        end
    endtask

    // One-cycle read access; expected bd is queued for the monitor.
    task automatic bus_read(input logic reg_sel, input logic [3:0] exp, input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        bus.sser_n = 1'b0;
        bus.ba13   = 1'b0;
        bus.ba12   = 1'b1;
        bus.ba7    = reg_sel;
        bus.br_w   = 1'b1;
        @(negedge clk);
        bus.br_w   = 1'b0;
        bus.sser_n = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: compare bd at the start of every drive window.
    initial begin
        mon_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (bus.bd_oe && !mon_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_read: bd=%h with nothing expected", bus.bd);
                end else begin
                    mon_exp  = exp_q.pop_front();
                    mon_name = name_q.pop_front();
                    check(mon_name, bus.bd, mon_exp);
                end
            end
            mon_prev = bus.bd_oe;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.sser_n = 1'b1;
        bus.ba13   = 1'b0;
        bus.ba12   = 1'b0;
        bus.ba7    = 1'b0;
        bus.br_w   = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_rdy",   {3'b0, bus.rdy},   4'h0);
        check("rst_perr",  {3'b0, bus.perr},  4'h0);
        check("rst_ovr",   {3'b0, bus.ovr},   4'h0);
        check("rst_bd",    bus.bd,            4'h0);
        check("rst_bd_oe", {3'b0, bus.bd_oe}, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(1'b1, 4'b0000, "status_after_reset");

        // Single frame 4'hA: entry appears on the clock after the stop sample.
        send_frame(4'hA, 1'b1, 7);
        @(negedge clk);
        check("rdy_at_stop_sample", {3'b0, bus.rdy}, 4'h0);
        @(negedge clk);
        check("rdy_after_push", {3'b0, bus.rdy}, 4'h1);
        bus_read(1'b0, 4'hA, "data_A");
        check("rdy_after_read_A", {3'b0, bus.rdy}, 4'h0);

        // Three frames, no reads: third overruns.
        send_frame(4'h1, 1'b0, 7);
        send_frame(4'h2, 1'b0, 7);
        send_frame(4'h3, 1'b1, 7);
        repeat (2) @(negedge clk);
        bus_read(1'b1, 4'b1011, "status_overrun");
        bus_read(1'b1, 4'b0011, "status_ovr_cleared");
        bus_read(1'b0, 4'h1, "data_1");
        bus_read(1'b0, 4'h2, "data_2");
        check("rdy_after_drain", {3'b0, bus.rdy}, 4'h0);
        bus_read(1'b1, 4'b0000, "status_drained");

        // 4'h5 has two ones, so parity bit 0 makes the frame bad.
        send_frame(4'h5, 1'b0, 7);
        repeat (2) @(negedge clk);
        check("rdy_bad_parity", {3'b0, bus.rdy}, 4'h0);
        bus_read(1'b1, 4'b0100, "status_perr");
        bus_read(1'b1, 4'b0000, "status_perr_cleared");

        // One-clock glitch: false start, nothing received.
        sdin = 1'b0;
        @(negedge clk);
        sdin = 1'b1;
        repeat (40) @(negedge clk);
        check("rdy_after_glitch", {3'b0, bus.rdy}, 4'h0);
        bus_read(1'b1, 4'b0000, "status_after_glitch");
        send_frame(4'h6, 1'b1, 7);
        repeat (2) @(negedge clk);
        bus_read(1'b0, 4'h6, "data_6_after_glitch");

        // Fill with 7, 8, then read head on the same clock as frame 9's push.
        send_frame(4'h7, 1'b0, 7);
        send_frame(4'h8, 1'b0, 7);
        fork
            send_frame(4'h9, 1'b1, 7);
            begin
                repeat (7 * OVS) @(negedge clk);
                bus_read(1'b0, 4'h7, "data_7_collision");
            end
        join
        check("rdy_after_collision", {3'b0, bus.rdy}, 4'h1);
        bus_read(1'b1, 4'b0011, "status_collision_no_ovr");
        bus_read(1'b0, 4'h8, "data_8");
        bus_read(1'b0, 4'h9, "data_9");
        bus_read(1'b1, 4'b0000, "status_after_collision");

        // Reset during d2 with an entry already queued.
        send_frame(4'hC, 1'b1, 7);
        repeat (2) @(negedge clk);
        check("rdy_before_reset", {3'b0, bus.rdy}, 4'h1);
        send_frame(4'hF, 1'b1, 3);
        sdin = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_rdy",   {3'b0, bus.rdy},  4'h0);
        check("midrst_perr",  {3'b0, bus.perr}, 4'h0);
        check("midrst_ovr",   {3'b0, bus.ovr},  4'h0);
        check("midrst_bd",    bus.bd,           4'h0);
        rst_n = 1'b1;
        repeat (10 * OVS) @(negedge clk);
        check("rdy_after_midrst", {3'b0, bus.rdy}, 4'h0);
        send_frame(4'hF, 1'b1, 7);
        repeat (2) @(negedge clk);
        bus_read(1'b1, 4'b0001, "status_F_ready");
        bus_read(1'b0, 4'hF, "data_F");
        bus_read(1'b1, 4'b0000, "status_final");

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL reads_unchecked: %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
